// File: rtl/cpu_seq_if.sv
// Sequencer handshake bundle: run control in, datapath strobes out.
// instr_cnt exists only when CPU_SEQ_INSTR_CNT_EN is defined.
interface cpu_seq_if;
   logic        ena;
   logic [2:0]  opcode;
   logic        zero;
   logic        load_ir;
   logic        rd;
   logic        wr;
   logic        inc_pc;
   logic        load_pc;
   logic        load_acc;
   logic        datactl_ena;
   logic        halt;
`ifdef CPU_SEQ_INSTR_CNT_EN
   logic [15:0] instr_cnt;

   modport master (
      output ena, opcode, zero,
      input  load_ir, rd, wr, inc_pc,
      input  load_pc, load_acc,
      input  datactl_ena, halt,
      input  instr_cnt
   );

   modport slave (
      input  ena, opcode, zero,
      output load_ir, rd, wr, inc_pc,
      output load_pc, load_acc,
      output datactl_ena, halt,
      output instr_cnt
   );
`else
   modport master (
      output ena, opcode, zero,
      input  load_ir, rd, wr, inc_pc,
      input  load_pc, load_acc,
      input  datactl_ena, halt
   );

   modport slave (
      input  ena, opcode, zero,
      output load_ir, rd, wr, inc_pc,
      output load_pc, load_acc,
      output datactl_ena, halt
   );
`endif
endinterface

// File: rtl/cpu_sequencer.sv
// Eight-step instruction sequencer with HALTED state and registered strobes.
// Optional retired-instruction counter: define CPU_SEQ_INSTR_CNT_EN.
module cpu_sequencer (
   input  logic      clk1,
   input  logic      rst,
   cpu_seq_if.slave  bus
);

   typedef enum logic [3:0] {
      S0, S1, S2, S3, S4, S5, S6, S7, HALTED
   } state_t;

   localparam logic [2:0] HLT = 3'b000;
   localparam logic [2:0] SKZ = 3'b001;
   localparam logic [2:0] ADD = 3'b010;
   localparam logic [2:0] AND = 3'b011;
   localparam logic [2:0] XOR = 3'b100;
   localparam logic [2:0] LDA = 3'b101;
   localparam logic [2:0] STO = 3'b110;
   localparam logic [2:0] JMP = 3'b111;

   typedef struct packed {
      logic load_ir;
      logic rd;
      logic wr;
      logic inc_pc;
      logic load_pc;
      logic load_acc;
      logic datactl_ena;
      logic halt;
   } ctl_t;

   state_t state;
   state_t state_nx;
   ctl_t   ctl_q;
   ctl_t   ctl_d;
   logic   alu_op;
   logic   skip;

   assign alu_op = (bus.opcode == ADD) || (bus.opcode == AND) ||
                   (bus.opcode == XOR) || (bus.opcode == LDA);
   assign skip   = (bus.opcode == SKZ) && bus.zero;

   always_comb begin
      state_nx = S0;
      case (state)
         S0:      state_nx = S1;
         S1:      state_nx = S2;
         S2:      state_nx = S3;
         S3:      state_nx = (bus.opcode == HLT) ? HALTED : S4;
         S4:      state_nx = S5;
         S5:      state_nx = S6;
         S6:      state_nx = S7;
         S7:      state_nx = S0;
         HALTED:  state_nx = HALTED;
         default: state_nx = S0;
      endcase
   end

   // Strobes for the current step, registered so they appear one cycle later.
   always_comb begin
      ctl_d = '0;
      case (state)
         S0, S1: begin
            ctl_d.load_ir = 1'b1;
            ctl_d.rd      = 1'b1;
            ctl_d.inc_pc  = 1'b1;
         end
         S3: ctl_d.halt = (bus.opcode == HLT);
         S4: begin
            ctl_d.rd          = alu_op;
            ctl_d.load_pc     = (bus.opcode == JMP);
            ctl_d.datactl_ena = (bus.opcode == STO);
         end
         S5: begin
            ctl_d.rd          = alu_op;
            ctl_d.load_acc    = alu_op;
            ctl_d.load_pc     = (bus.opcode == JMP);
            ctl_d.inc_pc      = (bus.opcode == JMP) || skip;
            ctl_d.wr          = (bus.opcode == STO);
            ctl_d.datactl_ena = (bus.opcode == STO);
         end
         S6: begin
            ctl_d.rd          = alu_op;
            ctl_d.datactl_ena = (bus.opcode == STO);
         end
         S7:      ctl_d.inc_pc = skip;
         HALTED:  ctl_d.halt   = 1'b1;
         default: ctl_d = '0;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (rst || !bus.ena) begin
         state <= S0;
         ctl_q <= '0;
      end else begin
         state <= state_nx;
         ctl_q <= ctl_d;
      end
   end

   assign bus.load_ir     = ctl_q.load_ir;
   assign bus.rd          = ctl_q.rd;
   assign bus.wr          = ctl_q.wr;
   assign bus.inc_pc      = ctl_q.inc_pc;
   assign bus.load_pc     = ctl_q.load_pc;
   assign bus.load_acc    = ctl_q.load_acc;
   assign bus.datactl_ena = ctl_q.datactl_ena;
   assign bus.halt        = ctl_q.halt;

`ifdef CPU_SEQ_INSTR_CNT_EN
   logic [15:0] cnt_q;

   // Only a completed S7->S0 step retires an instruction.
   always_ff @(posedge clk1) begin
      if (rst)
         cnt_q <= 16'h0000;
      else if (bus.ena && (state == S7))
         cnt_q <= cnt_q + 16'h0001;
   end

   assign bus.instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: strobe tables per opcode, halt, aborts.
// Counter checks are compiled in only with CPU_SEQ_INSTR_CNT_EN.
module tb_cpu_sequencer;

   localparam logic [2:0] HLT = 3'b000;
   localparam logic [2:0] SKZ = 3'b001;
   localparam logic [2:0] ADD = 3'b010;
   localparam logic [2:0] AND = 3'b011;
   localparam logic [2:0] XOR = 3'b100;
   localparam logic [2:0] LDA = 3'b101;
   localparam logic [2:0] STO = 3'b110;
   localparam logic [2:0] JMP = 3'b111;

   // Phase tables, S0 in the top byte; bit order
   // load_ir rd wr inc_pc load_pc load_acc datactl_ena halt.
   localparam logic [63:0] T_ALU  = 64'hD0D0_0000_4044_4000;
   localparam logic [63:0] T_STO  = 64'hD0D0_0000_0222_0200;
   localparam logic [63:0] T_JMP  = 64'hD0D0_0000_0818_0000;
   localparam logic [63:0] T_SKZ1 = 64'hD0D0_0000_0010_0010;
   localparam logic [63:0] T_SKZ0 = 64'hD0D0_0000_0000_0000;

   logic        clk1;
   logic        rst;
   int          total;
   int          bad;
   logic [15:0] exp_cnt;
   logic [7:0]  outs;

   cpu_seq_if bus ();

   cpu_sequencer dut (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus.slave)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   assign outs = {bus.load_ir, bus.rd, bus.wr, bus.inc_pc,
                  bus.load_pc, bus.load_acc, bus.datactl_ena,
                  bus.halt};

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_cnt(input string tag);
`ifdef CPU_SEQ_INSTR_CNT_EN
      total++;
      assert (bus.instr_cnt === exp_cnt) else begin
         bad++;
         $error("FAIL %s cnt got=%h exp=%h", tag, bus.instr_cnt,
                exp_cnt);
      end
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   // Starts with the FSM in S0; leaves it in S0 after retiring.
   task automatic run_instr(input string tag, input logic [2:0] op,
                            input logic z, input logic [63:0] tbl);
      logic [7:0] e;
      bus.opcode = op;
      bus.zero   = z;
      for (int k = 0; k < 8; k++) begin
         step();
         e = tbl[63-8*k -: 8];
         chk($sformatf("%s_s%0d", tag, k), outs, e);
         total++;
         assert (!(bus.rd && bus.wr)) else begin
            bad++;
            $error("FAIL %s_rdwr got=1 exp=0", tag);
         end
      end
      exp_cnt = exp_cnt + 16'h0001;
      chk_cnt(tag);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      exp_cnt    = 16'h0000;
      rst        = 1'b1;
      bus.ena    = 1'b0;
      bus.opcode = HLT;
      bus.zero   = 1'b0;
      step();
      step();
      chk("reset", outs, 8'h00);
      chk_cnt("reset");
      rst     = 1'b0;
      bus.ena = 1'b1;

      run_instr("lda", LDA, 1'b0, T_ALU);
      run_instr("sto", STO, 1'b1, T_STO);
      run_instr("jmp", JMP, 1'b0, T_JMP);
      run_instr("skz1", SKZ, 1'b1, T_SKZ1);
      run_instr("skz0", SKZ, 1'b0, T_SKZ0);
      run_instr("add", ADD, 1'b1, T_ALU);
      run_instr("xor", XOR, 1'b0, T_ALU);

      bus.opcode = LDA;
      for (int k = 0; k < 4; k++) step();
      chk("pre_abort", outs, 8'h00);
      bus.ena = 1'b0;
      step();
      chk("abort", outs, 8'h00);
      chk_cnt("abort");
      bus.ena = 1'b1;
      run_instr("and", AND, 1'b0, T_ALU);

      bus.opcode = STO;
      for (int k = 0; k < 3; k++) step();
      rst = 1'b1;
      step();
      chk("mid_rst", outs, 8'h00);
      chk_cnt("mid_rst");
      rst = 1'b0;
      run_instr("lda2", LDA, 1'b0, T_ALU);

`ifdef CPU_SEQ_INSTR_CNT_EN
      force dut.cnt_q = 16'hFFFF;
      #1;
      release dut.cnt_q;
      exp_cnt = 16'hFFFF;
      chk_cnt("preload");
      run_instr("wrap", JMP, 1'b0, T_JMP);
`endif

      bus.opcode = HLT;
      step();
      chk("hlt_s0", outs, 8'hD0);
      step();
      chk("hlt_s1", outs, 8'hD0);
      step();
      chk("hlt_s2", outs, 8'h00);
      step();
      chk("hlt_s3", outs, 8'h01);
      bus.opcode = LDA;
      for (int k = 0; k < 20; k++) begin
         step();
         chk($sformatf("halted_%0d", k), outs, 8'h01);
      end
      chk_cnt("halted");
      bus.ena = 1'b0;
      step();
      chk("unhalt", outs, 8'h00);
      bus.ena = 1'b1;
      run_instr("restart", JMP, 1'b1, T_JMP);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have port clk1, input, 1 bit: clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port ena, input, 1 bit: run enable; low holds the sequencer idle.
REQ-004 The block SHALL have port opcode, input, 3 bits: instruction opcode, opc_iraddr[15:13] of the instruction register; valid from step S2 onward.
REQ-005 The block SHALL have port zero, input, 1 bit: accumulator-zero flag.
REQ-006 The block SHALL have outputs load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena and halt, each 1 bit: instruction-register load, memory read, memory write, PC increment, PC load, accumulator load, data-bus drive and halted flag.
REQ-007 The block SHALL have port instr_cnt, output, 16 bits: retired-instruction count; present only under CPU_SEQ_INSTR_CNT_EN.
REQ-008 The block SHALL use the fixed opcode encodings HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.

Function
REQ-009 The block SHALL implement states S0..S7, stepped one per clk1 cycle while ena=1, plus a HALTED state.
REQ-010 Outputs SHALL be decoded from the registered state, opcode and zero; every output not listed for a step SHALL be 0.
REQ-011 The transitions SHALL be S0->S1->...->S7->S0 while ena=1.
REQ-012 In S3 with opcode=HLT, the next state SHALL be HALTED instead of S4.
REQ-013 S0 and S1: load_ir=1, rd=1, inc_pc=1; this gives exactly two consecutive loads, high byte then low byte.
REQ-014 S2: no output is asserted.
REQ-015 S3: HLT gives halt=1; other opcodes assert nothing.
REQ-016 S4: ADD/AND/XOR/LDA give rd=1; JMP gives load_pc=1; STO gives datactl_ena=1.
REQ-017 S5: ADD/AND/XOR/LDA give rd=1 and load_acc=1; JMP gives load_pc=1 and inc_pc=1; STO gives wr=1 and datactl_ena=1; SKZ with zero=1 gives inc_pc=1.
REQ-018 S6: ADD/AND/XOR/LDA give rd=1; STO gives datactl_ena=1.
REQ-019 S7: SKZ with zero=1 gives inc_pc=1; SKZ with zero=0 asserts nothing.
REQ-020 HALTED: halt=1 and all other outputs 0; the block SHALL stay there until rst=1 or ena=0.
REQ-021 When ena=0 at a clock edge, the next state SHALL be S0 with outputs held at 0; this applies mid-instruction and from HALTED.
REQ-022 After ena returns to 1, the sequence SHALL restart at S0, so the instruction register restarts on its high byte.
REQ-023 wr and rd SHALL never be 1 in the same cycle, and load_ir SHALL never be 1 outside S0/S1.

Reset
REQ-024 When rst=1 at a clock edge, the state SHALL become S0, overriding ena.
REQ-025 Outputs SHALL be 0 in the cycle after reset, and instr_cnt SHALL be 16'h0000.
REQ-026 Reset mid-instruction SHALL abandon that instruction without counting it.

Configuration
REQ-027 With macro CPU_SEQ_INSTR_CNT_EN defined, instr_cnt SHALL increment by 1 on every S7->S0 transition and wrap 16'hFFFF->16'h0000.
REQ-028 With CPU_SEQ_INSTR_CNT_EN defined, instr_cnt SHALL not increment on entry to HALTED or on an ena=0 abort.
REQ-029 Without CPU_SEQ_INSTR_CNT_EN, the instr_cnt port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover: rst=1 for 2 cycles, then ena=1 -> the cycle after reset has all outputs 0; then load_ir=rd=inc_pc=1 for exactly 2 cycles (S0, S1).
REQ-031 The bench SHALL cover: opcode=LDA with ena=1 -> rd=1 in S4-S6, load_acc=1 only in S5, wr=0 throughout, state returns to S0 after 8 cycles.
REQ-032 The bench SHALL cover: opcode=STO -> datactl_ena=1 in S4-S6, wr=1 only in S5, rd=0 in S2-S7; opcode=JMP -> load_pc=1 in S4-S5, inc_pc=1 in S5.
REQ-033 The bench SHALL cover: opcode=SKZ with zero=1 -> inc_pc=1 in S5 and S7; with zero=0 -> no output in S2-S7.
REQ-034 The bench SHALL cover: opcode=HLT -> halt=1 from S3 and held for 20 cycles with all other outputs 0; ena=0 for 1 cycle -> halt=0 and restart at S0.
REQ-035 The bench SHALL cover, under CPU_SEQ_INSTR_CNT_EN: ena=0 pulse in S4 -> S0 next cycle, instr_cnt unchanged; preload count of 65535 retirements -> next S7->S0 gives instr_cnt=16'h0000.
